// File: rtl/fir_seq_pkg.sv
// Shared width constant and FSM state encodings for the FIR byte-stream sequencer.
package fir_seq_pkg;
    localparam int BYTE_W = 8;

    typedef enum logic {
        ISSUE_IDLE,
        WAIT_FIR
    } issue_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_GAP,
        TX_WAIT
    } tx_state_t;
endpackage

// File: rtl/fir_stream_sequencer_if.sv
// UART/FIR-side signal bundle of the sequencer; master is the sequencer, slave the surrounding logic.
interface fir_stream_sequencer_if #(
    parameter int IN_BYTES   = 2,
    parameter int OUT_BYTES  = 2,
    parameter int FIFO_DEPTH = 4
);
    import fir_seq_pkg::*;

    logic [BYTE_W-1:0]           rx_data;
    logic                        rx_ready;
    logic [BYTE_W*IN_BYTES-1:0]  fir_in;
    logic                        fir_in_valid;
    logic [BYTE_W*OUT_BYTES-1:0] fir_out;
    logic                        fir_out_valid;
    logic [BYTE_W-1:0]           tx_data;
    logic                        tx_start;
    logic                        tx_busy;
    logic                        clr_err;
    logic                        overrun;
    logic [$clog2(FIFO_DEPTH):0] pending;

    modport master (
        input  rx_data, rx_ready, fir_out, fir_out_valid, tx_busy, clr_err,
        output fir_in, fir_in_valid, tx_data, tx_start, overrun, pending
    );

    modport slave (
        output rx_data, rx_ready, fir_out, fir_out_valid, tx_busy, clr_err,
        input  fir_in, fir_in_valid, tx_data, tx_start, overrun, pending
    );
endinterface

// File: rtl/fir_result_fifo.sv
// Result FIFO, registered pointers with an extra wrap bit; dout is the head entry combinationally.
// A push while full is accepted only when a pop frees the head in the same cycle.
module fir_result_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wp, rp;
    logic         wr_en, rd_en;

    assign count = wp - rp;
    assign empty = (wp == rp);
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;
    assign dout  = mem[rp[AW-1:0]];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wp[AW-1:0]] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (wr_en) wp <= wp + 1'b1;
            if (rd_en) rp <= rp + 1'b1;
        end
    end
endmodule

// File: rtl/fir_stream_sequencer.sv
// Assembles UART bytes into FIR samples (one-deep pending slot), queues results and serialises them MSB-first.
// Issue one cycle after the last byte; tx_start two cycles after a result lands in an idle, empty path.
module fir_stream_sequencer
    import fir_seq_pkg::*;
#(
    parameter int IN_BYTES   = 2,
    parameter int OUT_BYTES  = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    fir_stream_sequencer_if.master io
);
    localparam int IW  = BYTE_W * IN_BYTES;
    localparam int OW  = BYTE_W * OUT_BYTES;
    localparam int BCW = $clog2(IN_BYTES + 1);
    localparam int XCW = $clog2(OUT_BYTES + 1);

    // ---------------- byte assembly ----------------
    logic [IW-1:0]  asm_q, asm_nxt;
    logic [BCW-1:0] bcnt_q;
    logic           sample_done;

    always_comb begin
        asm_nxt                = asm_q << BYTE_W;
        asm_nxt[BYTE_W-1:0]    = io.rx_data;
    end

    assign sample_done = io.rx_ready && (bcnt_q == BCW'(IN_BYTES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            asm_q  <= '0;
            bcnt_q <= '0;
        end else if (io.rx_ready) begin
            asm_q  <= asm_nxt;
            bcnt_q <= sample_done ? '0 : bcnt_q + 1'b1;
        end
    end

    // ---------------- issue FSM ----------------
    issue_state_t iss_q, iss_nxt;
    logic [IW-1:0] fir_in_q, fir_in_nxt, slot_q, slot_nxt;
    logic          slot_full_q, slot_full_nxt, issue_q, issue_nxt;
    logic          sample_drop, result_acc;

    assign result_acc = io.fir_out_valid && (iss_q == WAIT_FIR);

    always_comb begin
        iss_nxt       = iss_q;
        fir_in_nxt    = fir_in_q;
        issue_nxt     = 1'b0;
        slot_nxt      = slot_q;
        slot_full_nxt = slot_full_q;
        sample_drop   = 1'b0;
        case (iss_q)
            ISSUE_IDLE: begin
                if (sample_done) begin
                    fir_in_nxt = asm_nxt;
                    issue_nxt  = 1'b1;
                    iss_nxt    = WAIT_FIR;
                end
            end
            WAIT_FIR: begin
                if (sample_done) begin
                    if (slot_full_q) begin
                        sample_drop = 1'b1;
                    end else begin
                        slot_nxt      = asm_nxt;
                        slot_full_nxt = 1'b1;
                    end
                end
                if (io.fir_out_valid) begin
                    if (slot_full_q) begin
                        fir_in_nxt    = slot_q;
                        issue_nxt     = 1'b1;
                        slot_full_nxt = 1'b0;
                    end else if (sample_done) begin
                        // sample completing alongside the result would otherwise strand in the slot
                        fir_in_nxt    = asm_nxt;
                        issue_nxt     = 1'b1;
                        slot_full_nxt = 1'b0;
                    end else begin
                        iss_nxt = ISSUE_IDLE;
                    end
                end
            end
            default: iss_nxt = ISSUE_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iss_q       <= ISSUE_IDLE;
            fir_in_q    <= '0;
            issue_q     <= 1'b0;
            slot_q      <= '0;
            slot_full_q <= 1'b0;
        end else begin
            iss_q       <= iss_nxt;
            fir_in_q    <= fir_in_nxt;
            issue_q     <= issue_nxt;
            slot_q      <= slot_nxt;
            slot_full_q <= slot_full_nxt;
        end
    end

    assign io.fir_in       = fir_in_q;
    assign io.fir_in_valid = issue_q;

    // ---------------- result FIFO ----------------
    logic [OW-1:0] fifo_dout;
    logic          fifo_full, fifo_empty, fifo_pop, result_drop;

    fir_result_fifo #(
        .W     (OW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (result_acc),
        .pop   (fifo_pop),
        .din   (io.fir_out),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (io.pending)
    );

    assign result_drop = result_acc && fifo_full && !fifo_pop;

    logic overrun_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                            overrun_q <= 1'b0;
        else if (sample_drop || result_drop) overrun_q <= 1'b1;
        else if (io.clr_err)                overrun_q <= 1'b0;
    end
    assign io.overrun = overrun_q;

    // ---------------- TX FSM ----------------
    tx_state_t       tx_q, tx_nxt;
    logic [OW-1:0]   sh_q, sh_nxt;
    logic [XCW-1:0]  idx_q, idx_nxt;
    logic [BYTE_W-1:0] txd_q, cur_byte;
    logic            tx_go;

    assign cur_byte = sh_q[OW-1 -: BYTE_W];

    always_comb begin
        tx_nxt   = tx_q;
        sh_nxt   = sh_q;
        idx_nxt  = idx_q;
        tx_go    = 1'b0;
        fifo_pop = 1'b0;
        case (tx_q)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    sh_nxt   = fifo_dout;
                    idx_nxt  = '0;
                    tx_nxt   = TX_START;
                end
            end
            TX_START: begin
                if (!io.tx_busy) begin
                    tx_go  = 1'b1;
                    tx_nxt = TX_GAP;
                end
            end
            TX_GAP: tx_nxt = TX_WAIT;
            TX_WAIT: begin
                if (!io.tx_busy) begin
                    if (idx_q < XCW'(OUT_BYTES - 1)) begin
                        sh_nxt  = sh_q << BYTE_W;
                        idx_nxt = idx_q + 1'b1;
                        tx_nxt  = TX_START;
                    end else begin
                        tx_nxt = TX_IDLE;
                    end
                end
            end
            default: tx_nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_q  <= TX_IDLE;
            sh_q  <= '0;
            idx_q <= '0;
            txd_q <= '0;
        end else begin
            tx_q  <= tx_nxt;
            sh_q  <= sh_nxt;
            idx_q <= idx_nxt;
            if (tx_go) txd_q <= cur_byte;
        end
    end

    // the byte is visible during its tx_start pulse and held until the next one
    assign io.tx_data  = tx_go ? cur_byte : txd_q;
    assign io.tx_start = tx_go;
endmodule

// File: tb/tb_fir_stream_sequencer.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_fir_stream_sequencer;
    import fir_seq_pkg::*;

    localparam int IN_BYTES   = 2;
    localparam int OUT_BYTES  = 2;
    localparam int FIFO_DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fir_stream_sequencer_if #(.IN_BYTES(IN_BYTES), .OUT_BYTES(OUT_BYTES), .FIFO_DEPTH(FIFO_DEPTH)) bus();

    fir_stream_sequencer #(.IN_BYTES(IN_BYTES), .OUT_BYTES(OUT_BYTES), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    logic tb_busy    = 1'b0;
    logic model_busy = 1'b0;
    assign bus.tx_busy = tb_busy | model_busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // observed traffic, logged mid-cycle
    logic [15:0] iss_q[$];
    int          iss_cyc[$];
    logic [7:0]  tx_q[$];
    int          tx_cyc[$];
    int          hold_viol = 0;
    logic [7:0]  last_tx   = 8'h00;
    logic        start_seen = 1'b0;
    bit          model_en  = 1'b0;
    int          busy_left = 0;

    always @(negedge clk) begin
        start_seen = bus.tx_start && !rst;
        if (rst) begin
            last_tx = 8'h00;
        end else begin
            if (bus.fir_in_valid) begin
                iss_q.push_back(bus.fir_in);
                iss_cyc.push_back(cyc);
            end
            if (bus.tx_start) begin
                tx_q.push_back(bus.tx_data);
                tx_cyc.push_back(cyc);
                last_tx = bus.tx_data;
            end else if (bus.tx_data !== last_tx) begin
                hold_viol++;
            end
        end
    end

    // transmitter model: busy for a random 1..4 cycles after each start
    always @(posedge clk) begin
        #1;
        if (!model_en) begin
            model_busy = 1'b0;
            busy_left  = 0;
        end else if (start_seen) begin
            busy_left  = $urandom_range(1, 4);
            model_busy = 1'b1;
        end else if (busy_left > 0) begin
            busy_left--;
            model_busy = (busy_left != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] txb(input int i);
        return (i < tx_q.size()) ? tx_q[i] : 8'hxx;
    endfunction
    function automatic logic [15:0] issv(input int i);
        return (i < iss_q.size()) ? iss_q[i] : 16'hxxxx;
    endfunction
    function automatic int issc(input int i);
        return (i < iss_cyc.size()) ? iss_cyc[i] : -1;
    endfunction
    function automatic int txc(input int i);
        return (i < tx_cyc.size()) ? tx_cyc[i] : -1000;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        iss_q.delete(); iss_cyc.delete(); tx_q.delete(); tx_cyc.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, output int e);
        bus.rx_data  = b;
        bus.rx_ready = 1'b1;
        tick();
        e = cyc;
        bus.rx_ready = 1'b0;
    endtask

    task automatic send_sample(input logic [15:0] s, output int e);
        int d;
        send_byte(s[15:8], d);
        send_byte(s[7:0], e);
    endtask

    task automatic send_fir(input logic [15:0] r, input logic clr, output int e);
        bus.fir_out       = r;
        bus.fir_out_valid = 1'b1;
        bus.clr_err       = clr;
        tick();
        e = cyc;
        bus.fir_out_valid = 1'b0;
        bus.clr_err       = 1'b0;
    endtask

    task automatic wait_tx(input int n, input int budget);
        int k = 0;
        while (tx_q.size() < n && k < budget) begin
            tick();
            k++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        checks++; if (bus.fir_in !== 16'h0)    begin errors++; $display("FAIL reset_fir_in got %h want 0000", bus.fir_in); end
        checks++; if (bus.fir_in_valid !== 1'b0) begin errors++; $display("FAIL reset_fir_in_valid got %b want 0", bus.fir_in_valid); end
        checks++; if (bus.tx_data !== 8'h0)    begin errors++; $display("FAIL reset_tx_data got %h want 00", bus.tx_data); end
        checks++; if (bus.tx_start !== 1'b0)   begin errors++; $display("FAIL reset_tx_start got %b want 0", bus.tx_start); end
        checks++; if (bus.overrun !== 1'b0)    begin errors++; $display("FAIL reset_overrun got %b want 0", bus.overrun); end
        checks++; if (bus.pending !== 3'd0)    begin errors++; $display("FAIL reset_pending got %0d want 0", bus.pending); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_assembly();
        int e;
        clear_mon();
        send_sample(16'h1234, e);
        tick(); tick();
        checks++; if (iss_q.size() != 1)        begin errors++; $display("FAIL asm_issue_count got %0d want 1", iss_q.size()); end
        checks++; if (issv(0) !== 16'h1234)     begin errors++; $display("FAIL asm_fir_in got %h want 1234", issv(0)); end
        checks++; if (issc(0) != e)             begin errors++; $display("FAIL asm_issue_cycle got %0d want %0d", issc(0), e); end
        checks++; if (bus.fir_in !== 16'h1234)  begin errors++; $display("FAIL asm_fir_in_held got %h want 1234", bus.fir_in); end
    endtask

    task automatic test_tx_word();
        int u;
        clear_mon();
        send_fir(16'hABCD, 1'b0, u);
        checks++; if (bus.pending !== 3'd1)     begin errors++; $display("FAIL txw_pending got %0d want 1", bus.pending); end
        wait_tx(2, 40);
        repeat (6) tick();
        checks++; if (tx_q.size() != 2)         begin errors++; $display("FAIL txw_pulse_count got %0d want 2", tx_q.size()); end
        checks++; if (txb(0) !== 8'hAB)         begin errors++; $display("FAIL txw_byte0 got %h want AB", txb(0)); end
        checks++; if (txb(1) !== 8'hCD)         begin errors++; $display("FAIL txw_byte1 got %h want CD", txb(1)); end
        checks++; if (txc(0) != u + 1)          begin errors++; $display("FAIL txw_start_cycle got %0d want %0d", txc(0), u + 1); end
        checks++; if (txc(1) - txc(0) < 3)      begin errors++; $display("FAIL txw_spacing got %0d want >=3", txc(1) - txc(0)); end
        checks++; if (bus.pending !== 3'd0)     begin errors++; $display("FAIL txw_drained got %0d want 0", bus.pending); end
    endtask

    task automatic test_pending_slot();
        int e, u;
        clear_mon();
        send_sample(16'h1111, e);
        send_sample(16'h5678, e);
        checks++; if (bus.overrun !== 1'b0)     begin errors++; $display("FAIL slot_no_overrun got %b want 0", bus.overrun); end
        send_sample(16'h9999, e);
        tick();
        checks++; if (bus.overrun !== 1'b1)     begin errors++; $display("FAIL slot_drop_overrun got %b want 1", bus.overrun); end
        checks++; if (iss_q.size() != 1)        begin errors++; $display("FAIL slot_held got %0d issues want 1", iss_q.size()); end
        send_fir(16'h0001, 1'b0, u);
        tick();
        checks++; if (issv(1) !== 16'h5678)     begin errors++; $display("FAIL slot_issue_val got %h want 5678", issv(1)); end
        checks++; if (issc(1) != u)             begin errors++; $display("FAIL slot_issue_cycle got %0d want %0d", issc(1), u); end
        send_fir(16'h0002, 1'b0, u);
        wait_tx(4, 80);
        repeat (4) tick();
        checks++; if (iss_q.size() != 2)        begin errors++; $display("FAIL slot_dropped_never_issued got %0d issues want 2", iss_q.size()); end
        checks++; if ({txb(0), txb(1), txb(2), txb(3)} !== 32'h0001_0002)
                                                begin errors++; $display("FAIL slot_results got %h want 00010002", {txb(0), txb(1), txb(2), txb(3)}); end
    endtask

    task automatic test_clr_err();
        bus.clr_err = 1'b1;
        tick();
        bus.clr_err = 1'b0;
        checks++; if (bus.overrun !== 1'b0)     begin errors++; $display("FAIL clr_alone got %b want 0", bus.overrun); end
    endtask

    task automatic test_fifo_full();
        logic [15:0] words[6];
        int e, u;
        clear_mon();
        tb_busy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            words[i] = 16'($urandom);
            send_sample(16'($urandom), e);
            send_fir(words[i], (i == 5), u);
            if (i == 4) begin
                checks++; if (bus.pending !== 3'd4) begin errors++; $display("FAIL full_pending got %0d want 4", bus.pending); end
                checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL full_no_overrun got %b want 0", bus.overrun); end
            end
        end
        checks++; if (bus.pending !== 3'd4)     begin errors++; $display("FAIL full_saturate got %0d want 4", bus.pending); end
        checks++; if (bus.overrun !== 1'b1)     begin errors++; $display("FAIL full_set_wins got %b want 1", bus.overrun); end
        checks++; if (tx_q.size() != 0)         begin errors++; $display("FAIL full_busy_hold got %0d bytes want 0", tx_q.size()); end
        tb_busy = 1'b0;
        wait_tx(10, 200);
        repeat (8) tick();
        checks++; if (tx_q.size() != 10)        begin errors++; $display("FAIL full_drain_count got %0d want 10", tx_q.size()); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({txb(2*i), txb(2*i+1)} !== words[i]) begin
                errors++; $display("FAIL full_drain_word%0d got %h want %h", i, {txb(2*i), txb(2*i+1)}, words[i]);
            end
        end
        bus.clr_err = 1'b1;
        tick();
        bus.clr_err = 1'b0;
    endtask

    task automatic test_reset_mid();
        int e, u;
        tb_busy = 1'b1;
        send_sample(16'h4242, e);
        send_fir(16'hBEEF, 1'b0, u);
        send_byte(8'h77, e);
        rst = 1'b1;
        tick();
        checks++; if ({bus.fir_in, bus.fir_in_valid, bus.tx_data, bus.tx_start, bus.overrun, bus.pending} !== '0)
            begin errors++; $display("FAIL rstmid_outputs got fir_in=%h v=%b txd=%h ts=%b ov=%b pend=%0d want all 0",
                                     bus.fir_in, bus.fir_in_valid, bus.tx_data, bus.tx_start, bus.overrun, bus.pending); end
        tb_busy = 1'b0;
        tick();
        rst = 1'b0;
        clear_mon();
        tick();
        send_sample(16'h9ABC, e);
        repeat (20) tick();
        checks++; if (issv(0) !== 16'h9ABC)     begin errors++; $display("FAIL rstmid_fir_in got %h want 9ABC", issv(0)); end
        checks++; if (issc(0) != e)             begin errors++; $display("FAIL rstmid_issue_cycle got %0d want %0d", issc(0), e); end
        checks++; if (tx_q.size() != 0)         begin errors++; $display("FAIL rstmid_inflight_discarded got %0d bytes want 0", tx_q.size()); end
        send_fir(16'h0000, 1'b0, u);
        wait_tx(2, 40);
        repeat (6) tick();
    endtask

    task automatic test_random();
        logic [15:0] exp_iss[$];
        logic [7:0]  exp_tx[$];
        logic [15:0] s, r;
        int e, u;
        clear_mon();
        model_en = 1'b1;
        for (int n = 0; n < 12; n++) begin
            for (int k = 0; k < 100 && bus.pending >= 3'd3; k++) tick();
            s = 16'($urandom);
            send_sample(s, e);
            exp_iss.push_back(s);
            for (int k = 0; k < 10 && iss_q.size() < n + 1; k++) tick();
            repeat ($urandom_range(0, 3)) tick();
            r = 16'($urandom);
            send_fir(r, 1'b0, u);
            exp_tx.push_back(r[15:8]);
            exp_tx.push_back(r[7:0]);
        end
        wait_tx(exp_tx.size(), 800);
        repeat (10) tick();
        model_en = 1'b0;
        checks++; if (iss_q.size() != exp_iss.size()) begin errors++; $display("FAIL rnd_issue_count got %0d want %0d", iss_q.size(), exp_iss.size()); end
        for (int i = 0; i < exp_iss.size(); i++) begin
            checks++; if (issv(i) !== exp_iss[i]) begin errors++; $display("FAIL rnd_issue%0d got %h want %h", i, issv(i), exp_iss[i]); end
        end
        checks++; if (tx_q.size() != exp_tx.size()) begin errors++; $display("FAIL rnd_tx_count got %0d want %0d", tx_q.size(), exp_tx.size()); end
        for (int i = 0; i < exp_tx.size(); i++) begin
            checks++; if (txb(i) !== exp_tx[i]) begin errors++; $display("FAIL rnd_tx%0d got %h want %h", i, txb(i), exp_tx[i]); end
        end
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL rnd_overrun got %b want 0", bus.overrun); end
        checks++; if (hold_viol != 0)       begin errors++; $display("FAIL tx_data_hold got %0d changes want 0", hold_viol); end
    endtask

    initial begin
        bus.rx_data       = 8'h00;
        bus.rx_ready      = 1'b0;
        bus.fir_out       = 16'h0000;
        bus.fir_out_valid = 1'b0;
        bus.clr_err       = 1'b0;
        test_reset();
        test_assembly();
        test_tx_word();
        test_pending_slot();
        test_clr_err();
        test_fifo_full();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
